// File: rtl/instr_mem_server_pkg.sv
// Shared definitions for the instruction memory server: FSM encoding,
// default storage depth and the word returned for idle or faulting fetches.
package instr_mem_server_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } state_e;

  localparam int          DEFAULT_DEPTH = 64;
  localparam int          WORD_W        = 32;
  // One wider than the pointer so a completely full memory (64 words) is countable.
  localparam int          COUNT_W       = 7;
  localparam logic [31:0] NOP_WORD      = 32'h0;

endpackage : instr_mem_server_pkg

// File: rtl/instr_ram.sv
// Single-port-write, single-port-read instruction store with a registered
// read data path. Holds no reset: contents survive reset and are only made
// visible again once a new program load sets loaded_count.
module instr_ram #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port and synchronous read port share the clock; the server never
  // enables both in the same cycle.
  // NOTE: the array has no reset on purpose -- resetting a memory turns it
  // into thousands of flops instead of a RAM macro, and the server masks
  // stale contents through loaded_count anyway.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : instr_ram

// File: rtl/instr_mem_server.sv
// Instruction memory server: accepts a program as a stream of words
// (LOAD), then answers processor fetches with one-cycle latency (SERVE).
// Fetches beyond the loaded program are acknowledged with a fault flag
// and a zero instruction word.
module instr_mem_server
  import instr_mem_server_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic [WORD_W-1:0]  load_data,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_ack,
  output logic [WORD_W-1:0]  instruction,
  output logic               fetch_fault,
  output logic [COUNT_W-1:0] loaded_count,
  output logic               state_ready
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               ack_q, ack_d;
  logic               fault_q, fault_d;
  logic               wr_en;
  logic               rd_en;
  logic               addr_in_range;
  logic [WORD_W-1:0]  rd_data;

  // Zero-extend both sides so the comparison works for any ADDR_W/COUNT_W mix.
  assign addr_in_range = 32'(fetch_addr) < 32'(count_q);

  // Next-state, pointer/count and fetch-issue decisions.
  // NOTE: every signal gets a default before the case statement; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    ack_d   = 1'b0;
    fault_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      LOAD: begin
        if (load_start) begin
          // Restart: the word presented alongside load_start is discarded.
          ptr_d   = '0;
          count_d = '0;
        end else if (load_valid) begin
          wr_en   = 1'b1;
          ptr_d   = ptr_q + PTR_W'(1);
          count_d = count_q + COUNT_W'(1);
          if (load_last || ptr_q == LAST_PTR) begin
            state_d = SERVE;
          end
        end
      end
      SERVE: begin
        if (load_start) begin
          // A new load takes priority over a fetch in the same cycle.
          state_d = LOAD;
          ptr_d   = '0;
          count_d = '0;
        end else if (fetch_req) begin
          ack_d   = 1'b1;
          fault_d = !addr_in_range;
          rd_en   = addr_in_range;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, count and fetch-response registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ack_q   <= ack_d;
      fault_q <= fault_d;
    end
  end

  instr_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (WORD_W),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (ptr_q),
    .wdata_i (load_data),
    .re_i    (rd_en),
    .raddr_i (fetch_addr[PTR_W-1:0]),
    .rdata_o (rd_data)
  );

  // The RAM output register keeps its last value; only a good ack exposes it.
  assign instruction  = (ack_q && !fault_q) ? rd_data : NOP_WORD;
  assign fetch_ack    = ack_q;
  assign fetch_fault  = fault_q;
  assign loaded_count = count_q;
  assign load_ready   = (state_q == LOAD);
  assign state_ready  = (state_q == SERVE);

endmodule : instr_mem_server

// File: tb/tb_instr_mem_server.sv
// Directed bench for instr_mem_server with a program-level reference model
// checked on every clock plus literal expectations at key points.
module tb_instr_mem_server;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        fetch_ack;
  logic [31:0] instruction;
  logic        fetch_fault;
  logic [6:0]  loaded_count;
  logic        state_ready;

  int n_vec = 0;
  int n_err = 0;

  instr_mem_server dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_ack    (fetch_ack),
    .instruction  (instruction),
    .fetch_fault  (fetch_fault),
    .loaded_count (loaded_count),
    .state_ready  (state_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: program-level view (mode, word count, stored words).
  // The write position is simply the number of words stored so far.
  int          m_mode;   // 0 idle, 1 loading, 2 serving
  int          m_count;
  logic [31:0] m_mem [64];
  logic        e_ack;
  logic        e_fault;
  logic [31:0] e_instr;

  always @(posedge clk) begin
    e_ack   = 1'b0;
    e_fault = 1'b0;
    e_instr = 32'h0;
    if (!reset) begin
      m_mode  = 0;
      m_count = 0;
    end else begin
      case (m_mode)
        0: if (load_start) begin m_mode = 1; m_count = 0; end
        1: begin
          if (load_start) m_count = 0;
          else if (load_valid) begin
            m_mem[m_count] = load_data;
            m_count++;
            if (load_last || m_count == 64) m_mode = 2;
          end
        end
        default: begin
          if (load_start) begin m_mode = 1; m_count = 0; end
          else if (fetch_req) begin
            e_ack = 1'b1;
            if (int'(fetch_addr) < m_count) e_instr = m_mem[fetch_addr];
            else e_fault = 1'b1;
          end
        end
      endcase
    end
    #1;
    check("m_ack",   32'(fetch_ack),    32'(e_ack));
    check("m_fault", 32'(fetch_fault),  32'(e_fault));
    check("m_instr", instruction,       e_instr);
    check("m_count", 32'(loaded_count), 32'(m_count));
    check("m_lrdy",  32'(load_ready),   32'(m_mode == 1));
    check("m_srdy",  32'(state_ready),  32'(m_mode == 2));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = 32'h0;
    load_last  = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = 8'h0;
  endtask

  task automatic fetch_check(input logic [7:0] addr, input logic [31:0] exp_i,
                             input logic exp_f, input string name);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    tick();
    fetch_req = 1'b0;
    check({name, "_ack"},   32'(fetch_ack),   32'd1);
    check({name, "_instr"}, instruction,      exp_i);
    check({name, "_fault"}, 32'(fetch_fault), 32'(exp_f));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    idle_inputs();
    tick(); tick();
    check("rst_count", 32'(loaded_count), 32'd0);
    check("rst_srdy",  32'(state_ready),  32'd0);
    check("rst_lrdy",  32'(load_ready),   32'd0);
    check("rst_ack",   32'(fetch_ack),    32'd0);
    check("rst_instr", instruction,       32'h0);

    // Short program of three words.
    reset = 1'b1;
    tick();
    load_start = 1'b1; tick(); load_start = 1'b0;
    check("load_rdy", 32'(load_ready), 32'd1);
    load_valid = 1'b1; load_data = 32'h11; tick();
    load_data = 32'h22; tick();
    load_data = 32'h33; load_last = 1'b1; tick();
    idle_inputs(); tick();
    check("p3_srdy",  32'(state_ready),  32'd1);
    check("p3_count", 32'(loaded_count), 32'd3);

    // Back-to-back fetches, then an out-of-range one.
    fetch_req = 1'b1; fetch_addr = 8'd0; tick();
    check("f0", instruction, 32'h11); fetch_addr = 8'd1; tick();
    check("f1", instruction, 32'h22); fetch_addr = 8'd2; tick();
    check("f2", instruction, 32'h33);
    check("f2_ack", 32'(fetch_ack), 32'd1);
    check("f2_fault", 32'(fetch_fault), 32'd0);
    fetch_addr = 8'd5; tick();
    fetch_req = 1'b0;
    check("oor_ack",   32'(fetch_ack),   32'd1);
    check("oor_instr", instruction,      32'h0);
    check("oor_fault", 32'(fetch_fault), 32'd1);
    tick();
    check("noreq_ack", 32'(fetch_ack), 32'd0);

    // load_valid in SERVE must not change anything.
    load_valid = 1'b1; load_data = 32'hDEAD_BEEF; tick(); load_valid = 1'b0;
    check("ign_count", 32'(loaded_count), 32'd3);

    // Collision: load_start beats fetch_req.
    load_start = 1'b1; fetch_req = 1'b1; fetch_addr = 8'd0; tick();
    idle_inputs();
    check("col_ack",   32'(fetch_ack),    32'd0);
    check("col_lrdy",  32'(load_ready),   32'd1);
    check("col_count", 32'(loaded_count), 32'd0);

    // Full 64-word load without load_last.
    for (int i = 0; i < 64; i++) begin
      load_valid = 1'b1; load_data = 32'hA000_0000 + 32'(i); tick();
    end
    idle_inputs();
    check("full_srdy",  32'(state_ready),  32'd1);
    check("full_count", 32'(loaded_count), 32'd64);
    fetch_check(8'd63, 32'hA000_003F, 1'b0, "full63");
    fetch_check(8'd0,  32'hA000_0000, 1'b0, "full0");
    fetch_check(8'd64, 32'h0,         1'b1, "full64");

    // Restart in the middle of a load.
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_valid = 1'b1; load_data = 32'h1; tick();
    load_data = 32'h2; tick();
    load_start = 1'b1; load_data = 32'h3; tick(); load_start = 1'b0;
    load_data = 32'h44; load_last = 1'b1; tick();
    idle_inputs();
    check("rs_count", 32'(loaded_count), 32'd1);
    fetch_check(8'd0, 32'h44, 1'b0, "rs0");

    // Reset mid-LOAD after two words, with a fetch request present.
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_valid = 1'b1; load_data = 32'h55; tick(); tick();
    reset = 1'b0; load_valid = 1'b0; fetch_req = 1'b1; tick();
    reset = 1'b1; tick();
    check("mr_ack",   32'(fetch_ack),    32'd0);
    check("mr_srdy",  32'(state_ready),  32'd0);
    check("mr_lrdy",  32'(load_ready),   32'd0);
    check("mr_count", 32'(loaded_count), 32'd0);
    idle_inputs();

    // Old contents are unreadable after a short reload.
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_valid = 1'b1; load_last = 1'b1; load_data = 32'h77; tick();
    idle_inputs();
    fetch_check(8'd1, 32'h0,  1'b1, "stale1");
    fetch_check(8'd0, 32'h77, 1'b0, "fresh0");

    // Reset with a fetch in flight: no ack afterwards.
    fetch_req = 1'b1; fetch_addr = 8'd0; reset = 1'b0; tick();
    check("rf_ack", 32'(fetch_ack), 32'd0);
    reset = 1'b1; idle_inputs(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_instr_mem_server

// File: doc/instr_mem_server.md
INSTR_MEM_SERVER -- requirements
Module: instr_mem_server

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit instruction words stored.
REQ-002 SHALL have parameter ADDR_W, default 8, width of fetch_addr.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset: sampled on the rising edge of clk, asserted when 0.
REQ-005 load_start  input  1  one-cycle pulse that begins a program load.
REQ-006 load_valid  input  1  load_data is valid this cycle.
REQ-007 load_data  input  32  instruction word to store.
REQ-008 load_last  input  1  qualifies load_data as the final word of the program.
REQ-009 load_ready  output  1  block accepts a load word this cycle.
REQ-010 fetch_req  input  1  processor fetch request.
REQ-011 fetch_addr  input  ADDR_W  word address of the requested instruction.
REQ-012 fetch_ack  output  1  instruction is valid this cycle.
REQ-013 instruction  output  32  fetched instruction word.
REQ-014 fetch_fault  output  1  qualifies fetch_ack: the address was at or beyond loaded_count.
REQ-015 loaded_count  output  7  number of words in the current program.
REQ-016 state_ready  output  1  block is in SERVE.

Function
REQ-017 FSM states SHALL be IDLE, LOAD and SERVE; the state after reset SHALL be IDLE.
REQ-018 IDLE SHALL go to LOAD on load_start, clearing the write pointer and loaded_count to 0.
REQ-019 load_ready SHALL be 1 only in LOAD.
REQ-020 LOAD SHALL write load_data to mem[ptr] on each cycle with load_valid && load_ready, then increment ptr and loaded_count.
REQ-021 LOAD SHALL go to SERVE on the cycle after an accepted word that has load_last=1 or is written to ptr==DEPTH-1.
REQ-022 load_valid SHALL be ignored outside LOAD.
REQ-023 load_start received during LOAD SHALL restart the load: ptr and loaded_count return to 0.
REQ-024 In SERVE, a fetch_req sampled on cycle N SHALL produce fetch_ack=1 on cycle N+1, with instruction equal to mem[fetch_addr] (latency 1).
REQ-025 Fetches SHALL be fully pipelined: back-to-back requests give back-to-back acks, one per cycle, in order.
REQ-026 If fetch_addr >= loaded_count, the ack SHALL still occur, with instruction=32'h0 and fetch_fault=1.
REQ-027 fetch_fault SHALL be 0 whenever fetch_ack is 0.
REQ-028 fetch_req outside SERVE SHALL be dropped: no ack.
REQ-029 When fetch_ack is 0, instruction SHALL hold 32'h0.
REQ-030 load_start in SERVE SHALL go to LOAD; if load_start and fetch_req are both 1 in the same cycle, load_start wins and the fetch is not acked.
REQ-031 Reads and writes SHALL never occur in the same cycle, since LOAD and SERVE are mutually exclusive.
REQ-032 DEPTH=64 SHALL allow loaded_count to reach 64, which is why loaded_count is 7 bits.

Reset
REQ-033 While reset=0 at a clock edge, the next state SHALL be: state=IDLE, ptr=0, loaded_count=0, fetch_ack=0, fetch_fault=0, instruction=32'h0, load_ready=0, state_ready=0.
REQ-034 Memory contents SHALL NOT be cleared by reset; they are not readable until a new load completes, because loaded_count is 0.
REQ-035 Reset asserted mid-LOAD or mid-fetch SHALL abandon the operation; no ack is issued on the following cycle.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, LOAD=2'd1, SERVE=2'd2), the default DEPTH, and the NOP/fault word 32'h0.
REQ-037 The storage array SHALL be a single sub-module, instr_ram: 1 write port, 1 synchronous read port, no reset.
REQ-038 The FSM, pointer, count and fetch logic SHALL reside in instr_mem_server.

Verification
REQ-039 Reset then load: load_start, then words 32'h11,32'h22,32'h33 with load_last on the third -> loaded_count=3, state_ready=1 two cycles after the last word.
REQ-040 Pipelined fetch: fetch addresses 0,1,2 on consecutive cycles -> acks on the next three cycles with 32'h11, 32'h22, 32'h33, fetch_fault=0.
REQ-041 Out-of-range fetch: fetch_addr=5 with loaded_count=3 -> next cycle fetch_ack=1, instruction=32'h0, fetch_fault=1.
REQ-042 Full load: 64 words with no load_last -> SERVE after word 63, loaded_count=64; fetch 63 returns the last word.
REQ-043 Collision: load_start and fetch_req in the same SERVE cycle -> no ack, state LOAD, loaded_count=0.
REQ-044 Reset mid-LOAD after 2 words, then fetch_req -> no ack, state IDLE, loaded_count=0.
